// File: rtl/row_reader_if.sv
// Row reader bus: row load side (load/row_in/load_rdy/abort) and pixel stream side
// (valid/ready plus pixel, column and line flags).
interface row_reader_if #(
    parameter int COLS  = 640,
    parameter int PIX_W = 8,
    parameter int COL_W = 13
);
    logic                    load;
    logic [COLS*PIX_W-1:0]   row_in;
    logic                    load_rdy;
    logic                    abort;
    logic                    out_valid;
    logic                    out_ready;
    logic [PIX_W-1:0]        out_pixel;
    logic [COL_W-1:0]        out_col;
    logic                    out_sol;
    logic                    out_eol;
    logic                    row_done;
    logic                    busy;

    // master: upstream row source plus downstream pixel sink; slave: the reader
    modport master (
        output load, row_in, abort, out_ready,
        input  load_rdy, out_valid, out_pixel, out_col, out_sol, out_eol, row_done, busy
    );

    modport slave (
        input  load, row_in, abort, out_ready,
        output load_rdy, out_valid, out_pixel, out_col, out_sol, out_eol, row_done, busy
    );
endinterface

// File: rtl/row_reader.sv
// Streams a packed pixel row out one pixel per valid/ready beat, with one pending row
// slot for bubble-free back-to-back rows. ROW_READER_MIRROR_EN selects horizontal mirror.
module row_reader #(
    parameter int COLS  = 640,
    parameter int PIX_W = 8,
    parameter int COL_W = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    row_reader_if.slave bus
);
    localparam int               IDX_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef logic [COLS-1:0][PIX_W-1:0] row_t;
    typedef enum logic { IDLE, STREAM } state_t;

    state_t           r_state;
    row_t             r_active;
    row_t             r_pending;
    logic             r_pend_v;
    logic [COL_W-1:0] r_col;
    logic             r_valid;
    logic [PIX_W-1:0] r_pixel;
    logic             r_sol;
    logic             r_eol;
    logic             r_row_done;
    logic             r_busy;
    logic             r_load_rdy;

    logic w_beat;
    logic w_last;

    assign w_beat = r_valid & bus.out_ready;
    assign w_last = (r_col == LAST_COL);

    function automatic logic [PIX_W-1:0] pick(input row_t row, input logic [COL_W-1:0] col);
        logic [IDX_W-1:0] w_idx;
`ifdef ROW_READER_MIRROR_EN
        w_idx = IDX_W'(COLS - 1) - col[IDX_W-1:0];
`else
        w_idx = col[IDX_W-1:0];
`endif
        return row[w_idx];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the row registers are plain flops, not RAM, so they can and do take
            // the async reset; a reset mid-row must leave no stale pixels behind.
            r_state    <= IDLE;
            r_active   <= '0;
            r_pending  <= '0;
            r_pend_v   <= 1'b0;
            r_col      <= '0;
            r_valid    <= 1'b0;
            r_pixel    <= '0;
            r_sol      <= 1'b0;
            r_eol      <= 1'b0;
            r_row_done <= 1'b0;
            r_busy     <= 1'b0;
            r_load_rdy <= 1'b1;
        end else begin
            r_row_done <= 1'b0;
            if (bus.abort) begin
                r_state    <= IDLE;
                r_pend_v   <= 1'b0;
                r_load_rdy <= 1'b1;
                r_col      <= '0;
                r_valid    <= 1'b0;
                r_sol      <= 1'b0;
                r_eol      <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        // pending slot is always empty here, so a load is always accepted
                        if (bus.load) begin
                            r_active <= bus.row_in;
                            r_col    <= '0;
                            r_pixel  <= pick(bus.row_in, '0);
                            r_valid  <= 1'b1;
                            r_sol    <= 1'b1;
                            r_eol    <= (COLS == 1);
                            r_busy   <= 1'b1;
                            r_state  <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (w_beat && !w_last) begin
                            r_col   <= r_col + 1'b1;
                            r_pixel <= pick(r_active, r_col + 1'b1);
                            r_sol   <= 1'b0;
                            r_eol   <= ((r_col + 1'b1) == LAST_COL);
                        end else if (w_beat) begin
                            r_row_done <= 1'b1;
                            r_col      <= '0;
                            r_sol      <= 1'b1;
                            r_eol      <= (COLS == 1);
                            if (r_pend_v) begin
                                r_active   <= r_pending;
                                r_pixel    <= pick(r_pending, '0);
                                r_pend_v   <= 1'b0;
                                r_load_rdy <= 1'b1;
                            end else if (bus.load) begin
                                r_active <= bus.row_in;
                                r_pixel  <= pick(bus.row_in, '0);
                            end else begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                                r_busy  <= 1'b0;
                                r_sol   <= 1'b0;
                                r_eol   <= 1'b0;
                            end
                        end
                        // a load landing on the final beat with no pending row went straight to active
                        if (bus.load && !r_pend_v && !(w_beat && w_last)) begin
                            r_pending  <= bus.row_in;
                            r_pend_v   <= 1'b1;
                            r_load_rdy <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.load_rdy  = r_load_rdy;
    assign bus.out_valid = r_valid;
    assign bus.out_pixel = r_pixel;
    assign bus.out_col   = r_col;
    assign bus.out_sol   = r_sol;
    assign bus.out_eol   = r_eol;
    assign bus.row_done  = r_row_done;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_row_reader.sv
// Self-checking bench for row_reader: queue-of-rows reference model compared every cycle,
// plus directed checks on beat/row_done counts, abort and asynchronous reset.
module tb_row_reader;
    localparam int COLS  = 640;
    localparam int PIX_W = 8;
    localparam int COL_W = 13;
    localparam int ROW_W = COLS * PIX_W;

    typedef logic [ROW_W-1:0] row_t;

`ifdef ROW_READER_MIRROR_EN
    localparam int RAMP_FIRST = (COLS - 1) % 256;
    localparam int RAMP_LAST  = 0;
`else
    localparam int RAMP_FIRST = 0;
    localparam int RAMP_LAST  = (COLS - 1) % 256;
`endif

    logic clk;
    logic rst_n;

    row_reader_if #(.COLS(COLS), .PIX_W(PIX_W), .COL_W(COL_W)) bus ();

    row_reader #(.COLS(COLS), .PIX_W(PIX_W), .COL_W(COL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: accepted rows in order (front = active), column of the active row
    row_t rows[$];
    int   idx      = 0;
    bit   exp_done = 1'b0;

    int dut_beats = 0;
    int dut_done  = 0;
    int first_pix = -1;
    int last_pix  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] ref_pixel(input row_t r, input int c);
`ifdef ROW_READER_MIRROR_EN
        return r[PIX_W*(COLS-1-c) +: PIX_W];
`else
        return r[PIX_W*c +: PIX_W];
`endif
    endfunction

    function automatic row_t ramp_row();
        row_t r;
        for (int c = 0; c < COLS; c++) r[PIX_W*c +: PIX_W] = PIX_W'(c % 256);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < COLS; c++) r[PIX_W*c +: PIX_W] = PIX_W'($urandom);
        return r;
    endfunction

    task automatic check_outputs();
        bit v;
        v = (rows.size() != 0);
        check("out_valid", 32'(bus.out_valid), 32'(v));
        check("busy",      32'(bus.busy),      32'(v));
        check("load_rdy",  32'(bus.load_rdy),  32'(rows.size() < 2));
        check("out_col",   32'(bus.out_col),   32'(idx));
        check("out_sol",   32'(bus.out_sol),   32'(v && idx == 0));
        check("out_eol",   32'(bus.out_eol),   32'(v && idx == COLS - 1));
        check("row_done",  32'(bus.row_done),  32'(exp_done));
        if (v) check("out_pixel", 32'(bus.out_pixel), 32'(ref_pixel(rows[0], idx)));
    endtask

    // one clock: check at negedge, drive inputs, advance model to the coming posedge
    task automatic step(input bit ld, input bit ab, input bit rdy, input row_t r);
        bit beat;
        check_outputs();
        if (bus.row_done) dut_done++;
        if (bus.out_valid && rdy) begin
            dut_beats++;
            if (bus.out_col == 0)        first_pix = int'(bus.out_pixel);
            if (bus.out_col == COLS - 1) last_pix  = int'(bus.out_pixel);
        end
        bus.load      = ld;
        bus.abort     = ab;
        bus.out_ready = rdy;
        bus.row_in    = r;
        beat     = (rows.size() != 0) && rdy;
        exp_done = 1'b0;
        if (ab) begin
            rows.delete();
            idx = 0;
        end else begin
            bit accept;
            accept = ld && (rows.size() < 2);
            if (beat) begin
                if (idx == COLS - 1) begin
                    exp_done = 1'b1;
                    void'(rows.pop_front());
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            if (accept) rows.push_back(r);
        end
        @(negedge clk);
    endtask

    task automatic drain(input bit rand_rdy, input int budget);
        int n;
        n = 0;
        while ((rows.size() != 0 || exp_done) && n < budget) begin
            step(1'b0, 1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, '0);
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
        step(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic clear_counts();
        dut_beats = 0;
        dut_done  = 0;
        first_pix = -1;
        last_pix  = -1;
    endtask

    initial begin
        bus.load      = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        bus.row_in    = '0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check_outputs();
        check("reset_pixel", 32'(bus.out_pixel), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ramp row, out_ready held high
        clear_counts();
        step(1'b1, 1'b0, 1'b1, ramp_row());
        check("t1_valid_after_load", 32'(bus.out_valid), 32'd1);
        drain(1'b0, 2000);
        check("t1_beats",     32'(dut_beats), 32'(COLS));
        check("t1_row_done",  32'(dut_done),  32'd1);
        check("t1_first_pix", 32'(first_pix), 32'(RAMP_FIRST));
        check("t1_last_pix",  32'(last_pix),  32'(RAMP_LAST));

        // 2: back-to-back rows, third load while pending slot full is dropped
        clear_counts();
        step(1'b1, 1'b0, 1'b1, rand_row());
        repeat (4) step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, rand_row());
        check("t2_load_rdy_low", 32'(bus.load_rdy), 32'd0);
        step(1'b1, 1'b0, 1'b1, rand_row());
        check("t2_queue_depth", 32'(rows.size()), 32'd2);
        drain(1'b0, 4000);
        check("t2_beats",    32'(dut_beats), 32'(2 * COLS));
        check("t2_row_done", 32'(dut_done),  32'd2);

        // 3: random backpressure
        clear_counts();
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rand_row());
        drain(1'b1, 5000);
        check("t3_beats",    32'(dut_beats), 32'(COLS));
        check("t3_row_done", 32'(dut_done),  32'd1);

        // 4: abort at col 100 with a pending row, together with a load
        clear_counts();
        step(1'b1, 1'b0, 1'b1, rand_row());
        step(1'b1, 1'b0, 1'b1, rand_row());
        while (idx < 100) step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 1'b1, rand_row());
        check("t4_valid_after_abort",    32'(bus.out_valid), 32'd0);
        check("t4_busy_after_abort",     32'(bus.busy),      32'd0);
        check("t4_load_rdy_after_abort", 32'(bus.load_rdy),  32'd1);
        step(1'b1, 1'b0, 1'b1, rand_row());
        check("t4_restart_col", 32'(bus.out_col), 32'd0);
        drain(1'b0, 2000);
        check("t4_row_done", 32'(dut_done), 32'd1);

        // 5: asynchronous reset mid-row
        step(1'b1, 1'b0, 1'b1, rand_row());
        step(1'b1, 1'b0, 1'b1, rand_row());
        while (idx < 300) step(1'b0, 1'b0, 1'b1, '0);
        bus.load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid",    32'(bus.out_valid), 32'd0);
        check("t5_async_busy",     32'(bus.busy),      32'd0);
        check("t5_async_load_rdy", 32'(bus.load_rdy),  32'd1);
        check("t5_async_col",      32'(bus.out_col),   32'd0);
        check("t5_async_pixel",    32'(bus.out_pixel), 32'd0);
        rows.delete();
        idx      = 0;
        exp_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, '0);
        clear_counts();
        step(1'b1, 1'b0, 1'b1, ramp_row());
        drain(1'b0, 2000);
        check("t5_beats_after_reset", 32'(dut_beats), 32'(COLS));
        check("t5_first_pix",         32'(first_pix), 32'(RAMP_FIRST));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
